// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-way TDM receive path: slot encoding (same as
// the mux select), FSM states and the default sync-miss tolerance.
package tdm_demux4_pkg;

  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

  localparam int MISS_MAX_DEF = 2;
  localparam int MISS_W       = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// 2-bit slot tracker: wraps 11->00 on inc, load jumps to slot B (the slot
// after a sync), clr returns to slot A.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic       clr,
  output logic [1:0] slot,
  output logic       is_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       slot <= SLOT_A;
    else if (clr)  slot <= SLOT_A;
    else if (load) slot <= SLOT_B;
    else if (inc)  slot <= slot + 2'd1;
  end

  assign is_last = (slot == SLOT_D);

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM link: locks to the slot-A sync, stages slots
// A..C and publishes a whole frame on the slot-D edge with a one-cycle strobe.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W        = 1,
  parameter int MISS_MAX = MISS_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [1:0]   slot
);

  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

  state_t              state, state_nx;
  logic [MISS_W-1:0]   miss, miss_nx, miss_inc;
  logic [W-1:0]        stg [3];
  logic                is_last;
  logic                ctr_inc, ctr_load, ctr_clr;
  logic                stg_we, out_we, err;
  logic [1:0]          stg_sel;

  tdm_slot_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc     (ctr_inc),
    .load    (ctr_load),
    .clr     (ctr_clr),
    .slot    (slot),
    .is_last (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      miss  <= '0;
    end else begin
      state <= state_nx;
      miss  <= miss_nx;
    end
  end

  assign miss_inc = (miss == MISS_LIM) ? miss : miss + 1'b1;

  always_comb begin
    state_nx = state;
    miss_nx  = miss;
    ctr_inc  = 1'b0;
    ctr_load = 1'b0;
    ctr_clr  = 1'b0;
    stg_we   = 1'b0;
    stg_sel  = slot;
    out_we   = 1'b0;
    err      = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            state_nx = LOCK;
            miss_nx  = '0;
            ctr_load = 1'b1;
            stg_we   = 1'b1;
            stg_sel  = SLOT_A;
          end
        end
        LOCK: begin
          // A sync anywhere but slot A realigns, even on the slot-D edge.
          if (sync && slot != SLOT_A) begin
            err      = 1'b1;
            miss_nx  = '0;
            ctr_load = 1'b1;
            stg_we   = 1'b1;
            stg_sel  = SLOT_A;
          end else if (slot == SLOT_A) begin
            if (sync) begin
              miss_nx = '0;
              stg_we  = 1'b1;
              ctr_inc = 1'b1;
            end else if (miss_inc == MISS_LIM) begin
              state_nx = HUNT;
              miss_nx  = '0;
              ctr_clr  = 1'b1;
            end else begin
              miss_nx = miss_inc;
              stg_we  = 1'b1;
              ctr_inc = 1'b1;
            end
          end else if (is_last) begin
            out_we  = 1'b1;
            ctr_inc = 1'b1;
          end else begin
            stg_we  = 1'b1;
            ctr_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) stg[i] <= '0;
    end else if (stg_we) begin
      for (int i = 0; i < 3; i++)
        if (stg_sel == 2'(i)) stg[i] <= din;
    end
  end

  // Slot D goes straight from din so all four channels land on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= out_we;
      sync_err    <= err;
      if (out_we) begin
        a <= stg[0];
        b <= stg[1];
        c <= stg[2];
        d <= din;
      end
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a W=8 and a default W=1 instance share stimulus; the
// W=1 instance sees din[0] and is held to bit 0 of the same expectations.
module tb_tdm_demux4;

  localparam int MM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, sync = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] a8, b8, c8, d8;
  logic       fv8, lk8, er8;
  logic [1:0] sl8;
  logic       a1, b1, c1, d1, fv1, lk1, er1;
  logic [1:0] sl1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(8), .MISS_MAX(MM)) dut8 (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .frame_valid(fv8), .locked(lk8), .sync_err(er8), .slot(sl8)
  );

  tdm_demux4 dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din[0]), .sync(sync),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .frame_valid(fv1), .locked(lk1), .sync_err(er1), .slot(sl1)
  );

  // Reference model: frame-level view of the receiver.
  logic       m_locked, m_fv, m_err;
  int         m_slot, m_miss;
  logic [7:0] m_stg [4];
  logic [7:0] m_out [4];

  task automatic model_reset();
    m_locked = 0; m_fv = 0; m_err = 0; m_slot = 0; m_miss = 0;
    for (int i = 0; i < 4; i++) begin m_stg[i] = '0; m_out[i] = '0; end
  endtask

  task automatic model_edge(input logic e, input logic s, input logic [7:0] dv);
    m_fv = 0; m_err = 0;
    if (!e) return;
    if (!m_locked) begin
      if (s) begin m_stg[0] = dv; m_slot = 1; m_locked = 1; m_miss = 0; end
    end else if (s && m_slot != 0) begin
      m_err = 1; m_stg[0] = dv; m_slot = 1; m_miss = 0;
    end else if (m_slot == 0) begin
      m_miss = s ? 0 : m_miss + 1;
      if (m_miss >= MM) begin m_locked = 0; m_slot = 0; m_miss = 0; end
      else begin m_stg[0] = dv; m_slot = 1; end
    end else begin
      m_stg[m_slot] = dv;
      if (m_slot == 3) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_stg[i];
        m_fv = 1;
      end
      m_slot = (m_slot + 1) % 4;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [36:0] act8, exp8;
    logic [8:0]  act1, exp1;
    act8 = {a8, b8, c8, d8, fv8, lk8, er8, sl8};
    exp8 = {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_locked, m_err, 2'(m_slot)};
    act1 = {a1, b1, c1, d1, fv1, lk1, er1, sl1};
    exp1 = {m_out[0][0], m_out[1][0], m_out[2][0], m_out[3][0], m_fv, m_locked, m_err, 2'(m_slot)};
    n_cmp++;
    if (act8 !== exp8 || act1 !== exp1) begin
      n_fail++;
      $display("FAIL %s t=%0t w8 actual=%h required=%h w1 actual=%h required=%h",
               tag, $time, act8, exp8, act1, exp1);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [7:0] dv);
    en = e; sync = s; din = dv;
    @(posedge clk);
    model_edge(e, s, dv);
    #1;
    cmp_model("model");
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after an edge.
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_outs", {a8, b8, c8, d8, fv8, lk8, er8, sl8, a1, b1, c1, d1, fv1, lk1, er1, sl1}, '0);
    en = 1'b0; sync = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en, sync;
    logic [7:0] din;
    logic [7:0] a, b, c, d;
    logic       fv, lk, err;
    logic [1:0] slot;
  } vec_t;

  function automatic vec_t mk(logic e, logic s, logic [7:0] dv, logic [31:0] abcd,
                              logic fv, logic lk, logic er, logic [1:0] sl);
    vec_t v;
    v.en = e; v.sync = s; v.din = dv;
    {v.a, v.b, v.c, v.d} = abcd;
    v.fv = fv; v.lk = lk; v.err = er; v.slot = sl;
    return v;
  endfunction

  vec_t tv [15];

  initial begin
    model_reset();
    // lock and frame, misaligned sync at slot C, then at slot D
    tv[0]  = mk(1, 1, 8'h01, 32'h00000000, 0, 1, 0, 2'd1);
    tv[1]  = mk(1, 0, 8'h00, 32'h00000000, 0, 1, 0, 2'd2);
    tv[2]  = mk(1, 0, 8'h01, 32'h00000000, 0, 1, 0, 2'd3);
    tv[3]  = mk(1, 0, 8'h01, 32'h01000101, 1, 1, 0, 2'd0);
    tv[4]  = mk(1, 1, 8'h11, 32'h01000101, 0, 1, 0, 2'd1);
    tv[5]  = mk(1, 0, 8'h22, 32'h01000101, 0, 1, 0, 2'd2);
    tv[6]  = mk(1, 1, 8'h33, 32'h01000101, 0, 1, 1, 2'd1);
    tv[7]  = mk(1, 0, 8'h44, 32'h01000101, 0, 1, 0, 2'd2);
    tv[8]  = mk(1, 0, 8'h55, 32'h01000101, 0, 1, 0, 2'd3);
    tv[9]  = mk(1, 0, 8'h66, 32'h33445566, 1, 1, 0, 2'd0);
    tv[10] = mk(0, 1, 8'h77, 32'h33445566, 0, 1, 0, 2'd0);
    tv[11] = mk(1, 1, 8'h10, 32'h33445566, 0, 1, 0, 2'd1);
    tv[12] = mk(1, 0, 8'h20, 32'h33445566, 0, 1, 0, 2'd2);
    tv[13] = mk(1, 0, 8'h30, 32'h33445566, 0, 1, 0, 2'd3);
    tv[14] = mk(1, 1, 8'h40, 32'h33445566, 0, 1, 1, 2'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {a8, b8, c8, d8, fv8, lk8, er8, sl8, a1, b1, c1, d1, fv1, lk1, er1, sl1}, '0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      en = tv[i].en; sync = tv[i].sync; din = tv[i].din;
      @(posedge clk);
      model_edge(tv[i].en, tv[i].sync, tv[i].din);
      #1;
      chk($sformatf("vec%0d", i), {a8, b8, c8, d8, fv8, lk8, er8, sl8},
          {tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].fv, tv[i].lk, tv[i].err, tv[i].slot});
      chk($sformatf("vec%0d_w1", i), {a1, b1, c1, d1, fv1, lk1, er1, sl1},
          {tv[i].a[0], tv[i].b[0], tv[i].c[0], tv[i].d[0], tv[i].fv, tv[i].lk, tv[i].err, tv[i].slot});
      cmp_model($sformatf("vec%0d_model", i));
    end

    // en gating: en=0 edges carry junk data and stray sync
    pulse_rst();
    step(1, 1, 8'h01); step(0, 1, 8'hFF); step(1, 0, 8'h00); step(0, 1, 8'hFE);
    step(1, 0, 8'h01); step(0, 0, 8'hAA);
    chk("gate_no_fv_early", {31'd0, fv8}, 0);
    step(1, 0, 8'h01);
    chk("gate_frame", {fv8, a8, b8, c8, d8}, {1'b1, 32'h01000101});

    // lock loss after MISS_MAX frames without sync, then relock
    pulse_rst();
    step(1, 1, 8'hA1); step(1, 0, 8'hB1); step(1, 0, 8'hC1); step(1, 0, 8'hD1);
    step(1, 0, 8'hA2); step(1, 0, 8'hB2); step(1, 0, 8'hC2); step(1, 0, 8'hD2);
    chk("miss1_delivered", {fv8, lk8, a8, b8, c8, d8}, {2'b11, 32'hA2B2C2D2});
    step(1, 0, 8'hA3);
    chk("miss2_unlock", {lk8, sl8, fv8, a8, b8, c8, d8}, {1'b0, 2'd0, 1'b0, 32'hA2B2C2D2});
    step(1, 0, 8'hB3);
    chk("hunt_ignores", {lk8, sl8}, 3'b000);
    step(1, 1, 8'h5A);
    chk("relock", {lk8, sl8}, {1'b1, 2'd1});

    // reset after slot B, then unsynced data
    pulse_rst();
    step(1, 1, 8'h01); step(1, 0, 8'h02);
    pulse_rst();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'($urandom));
      chk("post_rst_hunt", {fv8, lk8, er8}, 3'b000);
    end

    // wide data and hold through idle cycles
    pulse_rst();
    step(1, 1, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    chk("wide_frame", {fv8, a8, b8, c8, d8}, {1'b1, 32'h11223344});
    for (int i = 0; i < 10; i++) step(0, 1'($urandom), 8'($urandom));
    chk("wide_hold", {fv8, a8, b8, c8, d8}, {1'b0, 32'h11223344});

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic e, s;
      if ($urandom_range(399) == 0) begin
        pulse_rst();
      end else begin
        e = ($urandom_range(3) != 0);
        if (!m_locked)        s = ($urandom_range(9) < 3);
        else if (m_slot == 0) s = ($urandom_range(19) < 17);
        else                  s = ($urandom_range(49) < 2);
        step(e, s, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
